// File: rtl/except_ctrl.sv
// rtl/except_ctrl.sv - exception/interrupt sequencer between MEM stage and cp0_reg
module except_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter logic [31:0] EXC_OFFSET   = 32'h180,
    parameter logic [31:0] INT_OFFSET   = 32'h200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  int_i,
    input  logic        timer_int_i,
    input  logic        mem_valid_i,
    input  logic        mem_stall_i,
    input  logic        syscall_i,
    input  logic        inst_inval_i,
    input  logic        trap_i,
    input  logic        overflow_i,
    input  logic        eret_i,
    input  logic [31:0] mem_inst_addr_i,
    input  logic        mem_in_delayslot_i,
    input  logic [31:0] status_i,
    input  logic [31:0] cause_i,
    input  logic [31:0] epc_i,
    input  logic [31:0] ebase_i,
    output logic [5:0]  cp0_int_o,
    output logic [31:0] excepttype_o,
    output logic [31:0] current_inst_addr_o,
    output logic        is_in_delayslot_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o,
    output logic        busy_o
);
    localparam logic [31:0] INTERRUPT_EXP  = 32'h0000_0001;
    localparam logic [31:0] SYSCALL_EXP    = 32'h0000_0008;
    localparam logic [31:0] INST_INVAL_EXP = 32'h0000_000a;
    localparam logic [31:0] OVERFLOW_EXP   = 32'h0000_000c;
    localparam logic [31:0] TRAP_EXP       = 32'h0000_000d;
    localparam logic [31:0] ERET_EXP       = 32'h0000_000e;

    typedef enum logic {IDLE, FLUSH} state_t;

    state_t      state, state_next;
    logic [3:0]  cnt, cnt_next;
    logic [31:0] held_pc, held_pc_next;
    logic [5:0]  sync1, sync2;
    logic        int_pend, take;
    logic [31:0] exc_code, vec_pc;

    logic unused_status_cause;
    assign unused_status_cause = ^{status_i[31:16], status_i[7:2],
                                   cause_i[31:24], cause_i[22:16], cause_i[7:0]};

    // Two-flop synchroniser; the timer line is already in our clock domain
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1     <= '0;
            sync2     <= '0;
            cp0_int_o <= '0;
        end else begin
            sync1     <= int_i;
            sync2     <= sync1;
            cp0_int_o <= {sync2[5] | timer_int_i, sync2[4:0]};
        end
    end

    assign int_pend = (|(status_i[15:8] & cause_i[15:8])) & status_i[0] & ~status_i[1];
    assign take     = (state == IDLE) & mem_valid_i & ~mem_stall_i & ~rst;

    always_comb begin
        exc_code = '0;
        vec_pc   = ebase_i + EXC_OFFSET;
        if (int_pend) begin
            exc_code = INTERRUPT_EXP;
            vec_pc   = ebase_i + (cause_i[23] ? INT_OFFSET : EXC_OFFSET);
        end else if (inst_inval_i) begin
            exc_code = INST_INVAL_EXP;
        end else if (syscall_i) begin
            exc_code = SYSCALL_EXP;
        end else if (trap_i) begin
            exc_code = TRAP_EXP;
        end else if (overflow_i) begin
            exc_code = OVERFLOW_EXP;
        end else if (eret_i) begin
            exc_code = ERET_EXP;
            vec_pc   = epc_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            held_pc <= '0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            held_pc <= held_pc_next;
        end
    end

    always_comb begin
        state_next          = state;
        cnt_next            = cnt;
        held_pc_next        = held_pc;
        excepttype_o        = '0;
        current_inst_addr_o = '0;
        is_in_delayslot_o   = 1'b0;
        flush_o             = 1'b0;
        new_pc_o            = '0;
        busy_o              = 1'b0;
        case (state)
            IDLE: begin
                if (take && exc_code != '0) begin
                    excepttype_o        = exc_code;
                    current_inst_addr_o = mem_inst_addr_i;
                    is_in_delayslot_o   = mem_in_delayslot_i;
                    flush_o             = 1'b1;
                    new_pc_o            = vec_pc;
                    state_next          = FLUSH;
                    cnt_next            = 4'(FLUSH_CYCLES);
                    held_pc_next        = vec_pc;
                end
            end
            FLUSH: begin
                flush_o  = 1'b1;
                new_pc_o = held_pc;
                busy_o   = 1'b1;
                cnt_next = cnt - 4'd1;
                if (cnt <= 4'd1)
                    state_next = IDLE;
            end
        endcase
        // Outputs stay quiet during reset even if the FSM is mid-flush
        if (rst) begin
            excepttype_o        = '0;
            current_inst_addr_o = '0;
            is_in_delayslot_o   = 1'b0;
            flush_o             = 1'b0;
            new_pc_o            = '0;
            busy_o              = 1'b0;
        end
    end
endmodule

// File: tb/tb_except_ctrl.sv
// tb/tb_except_ctrl.sv - self-checking bench for except_ctrl
module tb_except_ctrl;
    localparam int FC = 2;
    localparam logic [31:0] C_INT   = 32'h1;
    localparam logic [31:0] C_SYS   = 32'h8;
    localparam logic [31:0] C_INVAL = 32'ha;
    localparam logic [31:0] C_OVF   = 32'hc;
    localparam logic [31:0] C_TRAP  = 32'hd;
    localparam logic [31:0] C_ERET  = 32'he;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1, timer_int = 1'b0, mem_valid = 1'b0, mem_stall = 1'b0;
    logic        syscall = 1'b0, inst_inval = 1'b0, trap = 1'b0, overflow = 1'b0, eret = 1'b0;
    logic        in_ds = 1'b0;
    logic [5:0]  int_in = 6'h3f;
    logic [31:0] inst_addr = '0, status = '0, cause = '0, epc = '0, ebase = '0;

    logic [5:0]  cp0_int;
    logic [31:0] excepttype, cur_addr, new_pc;
    logic        is_ds, flush, busy;

    except_ctrl #(.FLUSH_CYCLES(FC)) dut (
        .clk(clk), .rst(rst), .int_i(int_in), .timer_int_i(timer_int),
        .mem_valid_i(mem_valid), .mem_stall_i(mem_stall),
        .syscall_i(syscall), .inst_inval_i(inst_inval), .trap_i(trap),
        .overflow_i(overflow), .eret_i(eret),
        .mem_inst_addr_i(inst_addr), .mem_in_delayslot_i(in_ds),
        .status_i(status), .cause_i(cause), .epc_i(epc), .ebase_i(ebase),
        .cp0_int_o(cp0_int), .excepttype_o(excepttype),
        .current_inst_addr_o(cur_addr), .is_in_delayslot_o(is_ds),
        .flush_o(flush), .new_pc_o(new_pc), .busy_o(busy)
    );

    int n_cmp = 0, n_err = 0;

    // Reference state: flush cycles still owed, redirect PC, raw int_i seen at the last three edges
    int          m_left = 0;
    logic [31:0] m_held = '0;
    logic [5:0]  m_hist [3] = '{6'h0, 6'h0, 6'h0};
    logic        m_timer = 1'b0;

    logic [31:0] obs_exc, obs_pc;
    logic        obs_flush, obs_busy;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Inputs are already applied at the negedge; check, then advance one clock
    task automatic step();
        logic [31:0] e_exc, e_pc;
        logic        e_flush, e_busy, win, pend;
        #1;
        e_exc = '0; e_pc = '0; e_flush = 1'b0; e_busy = 1'b0; win = 1'b0;
        pend = (|(status[15:8] & cause[15:8])) && status[0] && !status[1];
        if (!rst) begin
            if (m_left > 0) begin
                e_flush = 1'b1; e_busy = 1'b1; e_pc = m_held;
            end else if (mem_valid && !mem_stall) begin
                win = 1'b1;
                if (pend) begin
                    e_exc = C_INT; e_pc = ebase + (cause[23] ? 32'h200 : 32'h180);
                end else if (inst_inval) begin e_exc = C_INVAL; e_pc = ebase + 32'h180; end
                else if (syscall)        begin e_exc = C_SYS;   e_pc = ebase + 32'h180; end
                else if (trap)           begin e_exc = C_TRAP;  e_pc = ebase + 32'h180; end
                else if (overflow)       begin e_exc = C_OVF;   e_pc = ebase + 32'h180; end
                else if (eret)           begin e_exc = C_ERET;  e_pc = epc; end
                else win = 1'b0;
                e_flush = win;
            end
        end
        chk("excepttype", excepttype, e_exc);
        chk("flush", 32'(flush), 32'(e_flush));
        chk("new_pc", new_pc, e_pc);
        chk("busy", 32'(busy), 32'(e_busy));
        chk("cp0_int", 32'(cp0_int), 32'({m_hist[2][5] | m_timer, m_hist[2][4:0]}));
        if (rst || win) begin
            chk("cur_addr", cur_addr, win ? inst_addr : 32'h0);
            chk("delayslot", 32'(is_ds), win ? 32'(in_ds) : 32'h0);
        end
        obs_exc = excepttype; obs_pc = new_pc; obs_flush = flush; obs_busy = busy;
        @(posedge clk);
        if (rst) begin
            m_left = 0; m_held = '0; m_hist = '{6'h0, 6'h0, 6'h0}; m_timer = 1'b0;
        end else begin
            if (m_left > 0) m_left--;
            else if (win) begin m_left = FC; m_held = e_pc; end
            m_hist[2] = m_hist[1]; m_hist[1] = m_hist[0]; m_hist[0] = int_in;
            m_timer = timer_int;
        end
        @(negedge clk);
    endtask

    task automatic clear_req();
        syscall = 0; inst_inval = 0; trap = 0; overflow = 0; eret = 0;
    endtask

    initial begin
        @(posedge clk);
        @(negedge clk);
        repeat (3) step();
        rst = 1'b0;
        repeat (3) step();
        chk("rst_sync_3f", 32'(cp0_int), 32'h3f);
        int_in = 6'h0;
        repeat (3) step();

        ebase = 32'h8000_0000; inst_addr = 32'h8000_1000; mem_valid = 1; syscall = 1;
        step();
        chk("sys_exc", obs_exc, C_SYS);
        chk("sys_pc", obs_pc, 32'h8000_0180);
        clear_req();
        repeat (2) begin
            step();
            chk("sys_flush_hold", 32'(obs_flush), 32'h1);
            chk("sys_pc_hold", obs_pc, 32'h8000_0180);
        end
        step();
        chk("sys_done", 32'({obs_flush, obs_busy}), 32'h0);

        status = 32'h0000_0401; cause = 32'h0000_0400; overflow = 1;
        step();
        chk("int_prio", obs_exc, C_INT);
        chk("int_pc", obs_pc, 32'h8000_0180);
        repeat (2) step();
        cause = 32'h0080_0400;
        step();
        chk("int_iv_pc", obs_pc, 32'h8000_0200);
        repeat (2) step();

        status = 32'h0000_0403;
        step();
        chk("masked_ovf", obs_exc, C_OVF);
        repeat (2) step();
        mem_stall = 1;
        repeat (4) begin
            step();
            chk("stall_block", 32'(obs_flush), 32'h0);
        end
        mem_stall = 0;
        step();
        chk("stall_release", obs_exc, C_OVF);
        clear_req();
        repeat (3) step();

        status = '0; epc = 32'hBFC0_0400; eret = 1;
        step();
        chk("eret_pc", obs_pc, 32'hBFC0_0400);
        repeat (2) begin
            step();
            chk("eret_ignored", obs_exc, 32'h0);
        end
        clear_req();
        step();

        ebase = 32'hFFFF_FF00; syscall = 1;
        step();
        chk("wrap_pc", obs_pc, 32'h0000_0080);
        clear_req();
        step();
        rst = 1;
        step();
        rst = 0;
        step();
        chk("rst_abort", 32'({obs_flush, obs_busy}), 32'h0);
        ebase = 32'h8000_0000; syscall = 1;
        step();
        chk("post_rst_sys", obs_exc, C_SYS);
        clear_req();
        repeat (3) step();

        for (int i = 0; i < 2000; i++) begin
            rst        = ($urandom_range(63) == 0);
            int_in     = 6'($urandom);
            timer_int  = ($urandom_range(7) == 0);
            mem_valid  = ($urandom_range(3) != 0);
            mem_stall  = ($urandom_range(3) == 0);
            syscall    = ($urandom_range(5) == 0);
            inst_inval = ($urandom_range(5) == 0);
            trap       = ($urandom_range(5) == 0);
            overflow   = ($urandom_range(5) == 0);
            eret       = ($urandom_range(5) == 0);
            in_ds      = 1'($urandom);
            inst_addr  = $urandom;
            status     = {16'h0, 8'($urandom), 6'h0, 2'($urandom)};
            cause      = {8'h0, 1'($urandom), 7'h0, 8'($urandom), 8'h0};
            epc        = $urandom;
            ebase      = $urandom;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/except_ctrl.md
Name: except_ctrl

Overview:
- Exception/interrupt sequencer between the MEM stage and cp0_reg.
- Synchronises hardware interrupt lines into CP0 and evaluates pending interrupts against Status/Cause.
- Arbitrates simultaneous exception requests by fixed priority and drives cp0_reg's excepttype/EPC inputs.
- Issues a multi-cycle pipeline flush with the redirect PC: exception vector or EPC on ERET.

Parameters:
- FLUSH_CYCLES, 2: flush_o cycles held after the decision cycle (1..15).
- EXC_OFFSET, 32'h180: general exception vector offset from EBase.
- INT_OFFSET, 32'h200: interrupt vector offset from EBase when Cause.IV=1.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high (`RstEnable)
- int_i  in  6  raw asynchronous hardware interrupt lines
- timer_int_i  in  1  timer_int_o from cp0_reg
- mem_valid_i  in  1  MEM stage holds a real instruction
- mem_stall_i  in  1  MEM stage stalled this cycle
- syscall_i, inst_inval_i, trap_i, overflow_i, eret_i  in  1 each  exception requests from MEM instruction
- mem_inst_addr_i  in  32  PC of MEM instruction
- mem_in_delayslot_i  in  1  MEM instruction is in a delay slot
- status_i, cause_i, epc_i, ebase_i  in  32 each  current cp0_reg outputs
- cp0_int_o  out  6  synchronised interrupts to cp0_reg int_i
- excepttype_o  out  `ExceptBus  to cp0_reg excepttype_i
- current_inst_addr_o  out  32  to cp0_reg
- is_in_delayslot_o  out  1  to cp0_reg
- flush_o  out  1  flush IF..MEM
- new_pc_o  out  32  redirect PC, valid while flush_o=1
- busy_o  out  1  sequencer not in IDLE

Behaviour:
- Reset (rst=1 at posedge): state IDLE, sync flops 0, cp0_int_o=0, flush count 0, held PC 0. Combinational outputs while rst=1: excepttype_o=0, flush_o=0, new_pc_o=0, busy_o=0, current_inst_addr_o=0, is_in_delayslot_o=0. Reset mid-FLUSH aborts to IDLE next cycle.
- Interrupt sync: 2-flop synchroniser per int_i bit; cp0_int_o registered = {sync[5] | timer_int_i, sync[4:0]}. Latency int_i -> cp0_int_o is 3 cycles; timer path is 1 cycle.
- int_pend = |(status_i[15:8] & cause_i[15:8]) & status_i[0] & ~status_i[1].
- take = state==IDLE & mem_valid_i & ~mem_stall_i & ~rst.
- Priority when take=1: int_pend > inst_inval_i > syscall_i > trap_i > overflow_i > eret_i. Only the winner is reported; losers are dropped because the instruction is flushed.
- Decision cycle (combinational, same cycle as take): excepttype_o = matching code (`INTERRUPT_EXP, `INST_INVAL_EXP, `SYSCALL_EXP, `TRAP_EXP, `OVERFLOW_EXP, `ERET_EXP); current_inst_addr_o=mem_inst_addr_i; is_in_delayslot_o=mem_in_delayslot_i; flush_o=1. cp0_reg commits EPC/Status/Cause on this edge.
- new_pc_o in decision cycle:
  - ERET: epc_i.
  - interrupt: ebase_i + (cause_i[23] ? INT_OFFSET : EXC_OFFSET).
  - others: ebase_i + EXC_OFFSET.
  - Value registered into held_pc.
- No winner or take=0: excepttype_o=0, flush_o=0, new_pc_o=0.
- FSM:
  - IDLE -> FLUSH on any winner; cnt loaded with FLUSH_CYCLES.
  - FLUSH: flush_o=1, new_pc_o=held_pc, excepttype_o=0, busy_o=1. Decrement cnt each cycle; -> IDLE when cnt reaches 1.
  - No request is accepted in FLUSH, even if valid, stalled or not.
- Stall: mem_stall_i=1 in IDLE blocks everything; a request persisting through the stall is taken on the first unstalled cycle.
- Address arithmetic is 32-bit modulo (wraps, no carry out).
- mem_valid_i=0: interrupt stays pending, is not taken, and is re-evaluated each cycle.
- Interrupt masked by Status.EXL=1 or IE=0; synchronous exceptions are still taken when EXL=1.

Test Plan:
- Reset: rst high 3 cycles with int_i=6'h3f -> all outputs 0. After release, cp0_int_o=6'h3f on the 3rd cycle.
- Syscall: ebase=32'h80000000, syscall_i=1, valid, PC 32'h80001000 -> excepttype_o=`SYSCALL_EXP 1 cycle; flush_o high 3 cycles; new_pc_o=32'h80000180 throughout; busy_o high 2 cycles.
- Interrupt priority: status=32'h0000_0401, cause=32'h0000_0400 with overflow_i=1 -> `INTERRUPT_EXP, new_pc 32'h80000180. With cause[23]=1 -> new_pc 32'h80000200.
- Masking: same but status[1]=1 -> overflow taken (`OVERFLOW_EXP). Stall high 4 cycles -> nothing until stall drops, then exactly one decision.
- ERET: epc_i=32'hBFC00400, eret_i=1 -> new_pc_o=32'hBFC00400. Second eret_i during FLUSH is ignored.
- Reset in FLUSH: rst asserted on 2nd flush cycle -> flush_o=0 and busy_o=0 the next cycle; a new syscall after release is handled normally.
